// File: rtl/mcu_symbol_arbiter.sv
// mcu_symbol_arbiter
//   Merges the per-channel entropy-coder symbol streams (Y, Cb, Cr, ...) onto one
//   output stream for the bitstream packer, in strict JPEG MCU order. Each channel
//   has its own first-word-fall-through symbol FIFO. The grant stays on one channel
//   until that channel's end-of-block symbol has been transferred, then moves on.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   in_vli/in_zeroNub/in_isDC/
//   in_last/in_valid [ROW]          per-channel coder symbols, no backpressure
//   out_vli/out_zeroNub/out_isDC/
//   out_last                        head symbol of the granted FIFO (0 when idle)
//   out_chan                        granted channel index
//   out_valid / out_ready           output handshake, transfer = valid & ready
//   mcu_done                        1-cycle pulse after the last channel's EOB transfer
//   mcu_cnt                         completed MCU count, wraps at 16 bits
//   ovf [ROW]                       sticky dropped-write flags (ARB_OVF_FLAG_EN only)
//
// Configuration
//   ARB_OVF_FLAG_EN  when defined, adds the ovf output port.

module mcu_symbol_arbiter #(
    parameter int DATA_WIDTH = 10,
    parameter int ROW        = 3,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [ROW-1:0][DATA_WIDTH-2:0]  in_vli,
    input  logic [ROW-1:0][3:0]             in_zeroNub,
    input  logic [ROW-1:0]                  in_isDC,
    input  logic [ROW-1:0]                  in_last,
    input  logic [ROW-1:0]                  in_valid,
    output logic [DATA_WIDTH-2:0]           out_vli,
    output logic [3:0]                      out_zeroNub,
    output logic                            out_isDC,
    output logic                            out_last,
    output logic [1:0]                      out_chan,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            mcu_done,
    output logic [15:0]                     mcu_cnt
`ifdef ARB_OVF_FLAG_EN
    ,
    output logic [ROW-1:0]                  ovf
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_WIDTH-2:0] vli;
        logic [3:0]            zero_nub;
        logic                  is_dc;
        logic                  last;
    } sym_t;

    typedef enum logic [1:0] {GNT_0, GNT_1, GNT_2, GNT_3} state_t;

    state_t             grant_q, grant_d;
    logic [1:0]         gidx;
    sym_t [ROW-1:0]     head;
    logic [ROW-1:0]     full, empty, push, pop;
    logic               xfer, eob_xfer;
    logic [15:0]        mcu_cnt_q;

    assign gidx     = grant_q;
    assign xfer     = out_valid && out_ready;
    assign eob_xfer = xfer && out_last;

    // ------------------------------------------------------------------
    // Per-channel symbol FIFOs
    // ------------------------------------------------------------------
    for (genvar i = 0; i < ROW; i++) begin : g_fifo
        sym_t             mem [FIFO_DEPTH];
        logic [PTR_W-1:0] wr_ptr, rd_ptr;
        logic [CNT_W-1:0] count;

        assign full[i]  = (count == CNT_W'(FIFO_DEPTH));
        assign empty[i] = (count == '0);
        assign pop[i]   = xfer && (gidx == 2'(i));
        // A full FIFO still takes the write when its head leaves in the same cycle.
        assign push[i]  = in_valid[i] && (!full[i] || pop[i]);
        assign head[i]  = mem[rd_ptr];

        // NOTE: the storage array has no reset; only pointers and count need one,
        // since an empty FIFO never exposes its contents.
        always_ff @(posedge clk) begin
            if (push[i]) begin
                mem[wr_ptr] <= '{vli: in_vli[i], zero_nub: in_zeroNub[i],
                                 is_dc: in_isDC[i], last: in_last[i]};
            end
        end

        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[i]) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop[i])  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push[i], pop[i]})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Output mux: head of the granted FIFO, zeroed when nothing is presented
    // ------------------------------------------------------------------
    always_comb begin
        out_valid   = !empty[gidx];
        out_chan    = gidx;
        out_vli     = '0;
        out_zeroNub = '0;
        out_isDC    = 1'b0;
        out_last    = 1'b0;
        if (out_valid) begin
            out_vli     = head[gidx].vli;
            out_zeroNub = head[gidx].zero_nub;
            out_isDC    = head[gidx].is_dc;
            out_last    = head[gidx].last;
        end
    end

    // ------------------------------------------------------------------
    // Grant FSM: advance only on an EOB transfer, wrap after channel ROW-1
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) grant_q <= GNT_0;
        else        grant_q <= grant_d;
    end

    // NOTE: grant_d is assigned a default before any branch, so no latch is inferred.
    always_comb begin
        grant_d = grant_q;
        if (eob_xfer) begin
            grant_d = (gidx == 2'(ROW - 1)) ? GNT_0 : state_t'(gidx + 2'd1);
        end
    end

    // ------------------------------------------------------------------
    // MCU tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcu_done  <= 1'b0;
            mcu_cnt_q <= '0;
        end else begin
            mcu_done <= eob_xfer && (gidx == 2'(ROW - 1));
            if (eob_xfer && (gidx == 2'(ROW - 1))) mcu_cnt_q <= mcu_cnt_q + 16'd1;
        end
    end

    assign mcu_cnt = mcu_cnt_q;

`ifdef ARB_OVF_FLAG_EN
    // Sticky per-channel flag for any write that was dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf <= '0;
        else        ovf <= ovf | (in_valid & ~push);
    end
`endif

endmodule

// File: tb/tb_mcu_symbol_arbiter.sv
// tb_mcu_symbol_arbiter
//   Directed bench for mcu_symbol_arbiter. A queue-based reference model tracks
//   the expected FIFO contents, grant, MCU pulse and count; a negedge process
//   compares the DUT against it every cycle. Literal expectations pin the model.

module tb_mcu_symbol_arbiter;

    localparam int DW    = 10;
    localparam int ROW   = 3;
    localparam int DEPTH = 16;
    localparam int SW    = DW + 5;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [ROW-1:0][DW-2:0]  in_vli = '0;
    logic [ROW-1:0][3:0]     in_zeroNub = '0;
    logic [ROW-1:0]          in_isDC = '0;
    logic [ROW-1:0]          in_last = '0;
    logic [ROW-1:0]          in_valid = '0;
    logic [DW-2:0]           out_vli;
    logic [3:0]              out_zeroNub;
    logic                    out_isDC, out_last;
    logic [1:0]              out_chan;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic                    mcu_done;
    logic [15:0]             mcu_cnt;
`ifdef ARB_OVF_FLAG_EN
    logic [ROW-1:0]          ovf;
`endif

    mcu_symbol_arbiter #(.DATA_WIDTH(DW), .ROW(ROW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_vli(in_vli), .in_zeroNub(in_zeroNub), .in_isDC(in_isDC),
        .in_last(in_last), .in_valid(in_valid),
        .out_vli(out_vli), .out_zeroNub(out_zeroNub), .out_isDC(out_isDC),
        .out_last(out_last), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready), .mcu_done(mcu_done), .mcu_cnt(mcu_cnt)
`ifdef ARB_OVF_FLAG_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one queue per channel, an integer grant, MCU counter
    // ------------------------------------------------------------------
    logic [SW-1:0]  mq [ROW][$];
    int             m_grant = 0;
    logic           m_done = 1'b0;
    logic [15:0]    m_cnt = '0;
    logic [ROW-1:0] m_ovf = '0;
    bit             load_req = 1'b0;
    logic [15:0]    load_val = '0;
    logic [SW-1:0]  m_hd;
    bit             m_eob;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROW; i++) mq[i].delete();
            m_grant = 0;
            m_done  = 1'b0;
            m_cnt   = '0;
            m_ovf   = '0;
        end else begin
            m_eob = 1'b0;
            if (mq[m_grant].size() > 0 && out_ready) begin
                m_hd  = mq[m_grant].pop_front();
                m_eob = m_hd[0];
            end
            m_done = m_eob && (m_grant == ROW - 1);
            if (m_done) m_cnt = m_cnt + 16'd1;
            for (int i = 0; i < ROW; i++) begin
                if (in_valid[i]) begin
                    if (mq[i].size() < DEPTH)
                        mq[i].push_back({in_vli[i], in_zeroNub[i], in_isDC[i], in_last[i]});
                    else
                        m_ovf[i] = 1'b1;
                end
            end
            if (m_eob) m_grant = (m_grant + 1) % ROW;
            if (load_req) m_cnt = load_val;
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle comparison and transfer log
    // ------------------------------------------------------------------
    int            chan_log [$];
    int            done_pulses = 0;
    logic          exp_v;
    logic [SW-1:0] exp_sym;

    always @(negedge clk) begin
        if (rst_n) begin
            exp_v = (mq[m_grant].size() > 0);
            if (exp_v) exp_sym = mq[m_grant][0];
            else       exp_sym = '0;
            check("out_valid", 32'(out_valid), 32'(exp_v));
            check("out_chan",  32'(out_chan), 32'(m_grant));
            check("out_sym",   32'({out_vli, out_zeroNub, out_isDC, out_last}), 32'(exp_sym));
            check("mcu_done",  32'(mcu_done), 32'(m_done));
            check("mcu_cnt",   32'(mcu_cnt), 32'(m_cnt));
`ifdef ARB_OVF_FLAG_EN
            check("ovf", 32'(ovf), 32'(m_ovf));
`endif
            if (out_valid && out_ready) chan_log.push_back(int'(out_chan));
            if (mcu_done) done_pulses++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 2 time units after the rising edge
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input int ch, input logic [8:0] vli, input bit last);
        in_valid          = '0;
        in_valid[ch]      = 1'b1;
        in_vli[ch]        = vli;
        in_zeroNub[ch]    = vli[3:0] ^ 4'h5;
        in_isDC[ch]       = vli[0];
        in_last[ch]       = last;
        tick();
        in_valid          = '0;
    endtask

    int            base;
    int            base_done;
    int            n_ch1;
    logic [SW-1:0] first_sym;

    initial begin
        // Reset
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mcu_cnt",   32'(mcu_cnt), 32'd0);
        check("rst_grant",     32'(out_chan), 32'd0);
        check("rst_mcu_done",  32'(mcu_done), 32'd0);
`ifdef ARB_OVF_FLAG_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        tick();

        // MCU order: channels written 2,1,0 but must leave as 0,1,2
        out_ready = 1'b1;
        base      = chan_log.size();
        base_done = done_pulses;
        for (int c = ROW - 1; c >= 0; c--)
            for (int k = 0; k < 3; k++)
                put(c, 9'(16 * c + k + 1), k == 2);
        repeat (8) tick();
        check("order_count", 32'(chan_log.size() - base), 32'd9);
        for (int k = 0; k < 9; k++)
            if (base + k < chan_log.size())
                check("order_chan", 32'(chan_log[base + k]), 32'(k / 3));
        check("order_done_pulses", 32'(done_pulses - base_done), 32'd1);
        check("order_mcu_cnt", 32'(mcu_cnt), 32'd1);

        // Backpressure: 4 symbols held on ch0 for 10 cycles
        out_ready = 1'b0;
        base      = chan_log.size();
        put(0, 9'h0A1, 1'b0);
        put(0, 9'h0A2, 1'b0);
        put(0, 9'h0A3, 1'b0);
        put(0, 9'h0A4, 1'b1);
        first_sym = {9'h0A1, 4'h1 ^ 4'h5, 1'b1, 1'b0};
        repeat (10) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_hold",  32'({out_vli, out_zeroNub, out_isDC, out_last}), 32'(first_sym));
        end
        tick();
        out_ready = 1'b1;
        repeat (6) tick();
        check("bp_drained", 32'(chan_log.size() - base), 32'd4);
        check("bp_grant_next", 32'(out_chan), 32'd1);

        // Overflow: 17 writes to ch1 with no drain
        out_ready = 1'b0;
        base      = chan_log.size();
        for (int k = 0; k < 17; k++) put(1, 9'(9'h040 + k), 1'b0);
        tick();
`ifdef ARB_OVF_FLAG_EN
        check("ovf_ch1", 32'(ovf), 32'b010);
`endif
        check("ovf_no_xfer", 32'(chan_log.size() - base), 32'd0);

        // Full FIFO: push and pop in the same cycle, then drain
        out_ready = 1'b1;
        put(1, 9'h077, 1'b1);
        repeat (20) tick();
        n_ch1 = 0;
        for (int k = base; k < chan_log.size(); k++)
            if (chan_log[k] == 1) n_ch1++;
        check("full_pushpop_count", 32'(n_ch1), 32'd17);
`ifdef ARB_OVF_FLAG_EN
        check("full_pushpop_ovf", 32'(ovf), 32'b010);
`endif
        put(2, 9'h001, 1'b1);
        repeat (3) tick();
        check("second_mcu_cnt", 32'(mcu_cnt), 32'd2);

        // Reset mid-block discards buffered symbols
        out_ready = 1'b0;
        put(0, 9'h111, 1'b0);
        put(0, 9'h112, 1'b0);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_cnt",   32'(mcu_cnt), 32'd0);
        check("midrst_chan",  32'(out_chan), 32'd0);
        tick();

        // Counter wrap: preload 0xFFFE, then complete two MCUs
        load_val = 16'hFFFE;
        load_req = 1'b1;
        tick();
        force dut.mcu_cnt_q = 16'hFFFE;
        release dut.mcu_cnt_q;
        load_req = 1'b0;
        @(negedge clk);
        check("wrap_preload", 32'(mcu_cnt), 32'hFFFE);
        tick();
        base_done = done_pulses;
        out_ready = 1'b1;
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < ROW; c++)
                put(c, 9'(9'h180 + 4 * m + c), 1'b1);
        repeat (4) tick();
        check("wrap_cnt",   32'(mcu_cnt), 32'd0);
        check("wrap_dones", 32'(done_pulses - base_done), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
